// File: rtl/sm3_pkg.sv
// sm3_pkg: SM3 word/block constants, expansion FSM states and rotate/P1 helpers
package sm3_pkg;
  localparam int SM3_WORD_W = 32;
  localparam int SM3_BLK_WORDS = 16;
  localparam int SM3_ROUNDS = 64;
  typedef logic [SM3_WORD_W-1:0] sm3_word_t;
  typedef enum logic {ST_LOAD, ST_RUN} sm3_expnd_st_e;
  function automatic sm3_word_t rotl32(sm3_word_t x, int unsigned n);
    return (x << n) | (x >> (SM3_WORD_W - n));
  endfunction
  function automatic sm3_word_t p1(sm3_word_t x);
    return x ^ rotl32(x, 15) ^ rotl32(x, 23);
  endfunction
endpackage

// File: rtl/sm3_msg_expnd_engine_if.sv
// sm3_msg_expnd_engine_if: beat input handshake plus round output stream (slave = engine, master = source/sink)
interface sm3_msg_expnd_engine_if #(parameter int INPT_DW = 32);
  logic [INPT_DW-1:0] inpt_data_i;
  logic               inpt_vld_i;
  logic               inpt_lst_i;
  logic               inpt_rdy_o;
  logic [31:0]        expnd_otpt_wj_o;
  logic [31:0]        expnd_otpt_wjj_o;
  logic               expnd_otpt_lst_o;
  logic               expnd_otpt_vld_o;
  modport slave (
    input  inpt_data_i, inpt_vld_i, inpt_lst_i,
    output inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o, expnd_otpt_lst_o, expnd_otpt_vld_o
  );
  modport master (
    output inpt_data_i, inpt_vld_i, inpt_lst_i,
    input  inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o, expnd_otpt_lst_o, expnd_otpt_vld_o
  );
endinterface

// File: rtl/sm3_expnd_wgen.sv
// sm3_expnd_wgen: combinational W[j+16] from window words w0,w3,w7,w10,w13 (in: i_w*, out: o_w16)
module sm3_expnd_wgen
  import sm3_pkg::*;
(
  input  sm3_word_t i_w0,
  input  sm3_word_t i_w3,
  input  sm3_word_t i_w7,
  input  sm3_word_t i_w10,
  input  sm3_word_t i_w13,
  output sm3_word_t o_w16
);
  assign o_w16 = p1(i_w0 ^ i_w7 ^ rotl32(i_w13, 15)) ^ rotl32(i_w3, 7) ^ i_w10;
endmodule

// File: rtl/sm3_msg_expnd_engine.sv
// sm3_msg_expnd_engine: loads 16-word blocks over bus (slave) and streams 64 rounds of Wj/W'j; ports clk, rst, bus
module sm3_msg_expnd_engine
  import sm3_pkg::*;
#(
  parameter int INPT_DW = 32
) (
  input logic                  clk,
  input logic                  rst,
  sm3_msg_expnd_engine_if.slave bus
);
  localparam int BEATS = SM3_BLK_WORDS / (INPT_DW / 32);
  sm3_expnd_st_e r_st, w_st_nxt;
  sm3_word_t     r_win [SM3_BLK_WORDS];
  sm3_word_t     w_win_nxt [SM3_BLK_WORDS];
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [5:0]    r_rnd, w_rnd_nxt;
  logic          r_mlst, w_mlst_nxt;
  sm3_word_t     r_wj, r_wjj;
  logic          r_lst, r_vld;
  logic          w_xfer, w_fin, w_run_nxt;
  sm3_word_t     w_push;
  logic [63:0]   w_beat;
  assign bus.inpt_rdy_o = (r_st == ST_LOAD) & ~rst;
  assign w_xfer = bus.inpt_rdy_o & bus.inpt_vld_i;
  assign w_fin = w_xfer & (r_cnt == 4'(BEATS - 1));
  assign w_beat = 64'(bus.inpt_data_i);
  assign w_run_nxt = w_st_nxt == ST_RUN;
  sm3_expnd_wgen u_wgen (
    .i_w0 (r_win[0]),
    .i_w3 (r_win[3]),
    .i_w7 (r_win[7]),
    .i_w10(r_win[10]),
    .i_w13(r_win[13]),
    .o_w16(w_push)
  );
  // The window is only touched on a real transfer or in RUN, so idle X data never enters it.
  always_comb begin
    w_st_nxt = r_st;
    w_win_nxt = r_win;
    w_cnt_nxt = r_cnt;
    w_rnd_nxt = r_rnd;
    w_mlst_nxt = r_mlst;
    if (r_st == ST_RUN) begin
      for (int k = 0; k < 15; k++) w_win_nxt[k] = r_win[k+1];
      w_win_nxt[15] = w_push;
      w_rnd_nxt = r_rnd + 6'd1;
      w_st_nxt = r_rnd == 6'd63 ? ST_LOAD : ST_RUN;
    end else if (w_xfer) begin
      if (INPT_DW == 64) begin
        for (int k = 0; k < 14; k++) w_win_nxt[k] = r_win[k+2];
        w_win_nxt[14] = w_beat[63:32];
      end else begin
        for (int k = 0; k < 15; k++) w_win_nxt[k] = r_win[k+1];
      end
      w_win_nxt[15] = w_beat[31:0];
      w_cnt_nxt = w_fin ? 4'd0 : r_cnt + 4'd1;
      w_mlst_nxt = w_fin ? bus.inpt_lst_i : r_mlst;
      w_st_nxt = w_fin ? ST_RUN : ST_LOAD;
    end
  end
  // Output registers are loaded from next-state values so round 0 shows right after the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= ST_LOAD;
      r_win <= '{default: '0};
      r_cnt <= '0;
      r_rnd <= '0;
      r_mlst <= 1'b0;
      r_wj <= '0;
      r_wjj <= '0;
      r_lst <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      r_win <= w_win_nxt;
      r_cnt <= w_cnt_nxt;
      r_rnd <= w_rnd_nxt;
      r_mlst <= w_mlst_nxt;
      r_vld <= w_run_nxt;
      r_wj <= w_run_nxt ? w_win_nxt[0] : '0;
      r_wjj <= w_run_nxt ? w_win_nxt[0] ^ w_win_nxt[4] : '0;
      r_lst <= w_run_nxt & w_mlst_nxt & (w_rnd_nxt == 6'd63);
    end
  end
  assign bus.expnd_otpt_wj_o = r_wj;
  assign bus.expnd_otpt_wjj_o = r_wjj;
  assign bus.expnd_otpt_lst_o = r_lst;
  assign bus.expnd_otpt_vld_o = r_vld;
  // The round counter leaves RUN by wrapping 63->0, so it must sit at zero throughout LOAD.
  a_rnd_idle_in_load: assert property (@(posedge clk) disable iff (rst) (r_st == ST_LOAD) |-> (r_rnd == 6'd0));
endmodule

// File: tb/tb_sm3_msg_expnd_engine.sv
// tb_sm3_msg_expnd_engine: randomized self-checking bench for both beat widths against an SM3 expansion model
module tb_sm3_msg_expnd_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sm3_msg_expnd_engine_if #(.INPT_DW(32)) b32 ();
  sm3_msg_expnd_engine_if #(.INPT_DW(64)) b64 ();
  sm3_msg_expnd_engine #(.INPT_DW(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  sm3_msg_expnd_engine #(.INPT_DW(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));
  int checks = 0;
  int errors = 0;
  logic [31:0] ew [68];
  logic [31:0] got_wj [64];
  logic [31:0] got_wjj [64];
  logic [31:0] blk_a [16];
  logic [31:0] blk_b [16];
  function automatic logic [31:0] rl(logic [31:0] x, int n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction
  task automatic model(input logic [31:0] blk [16]);
    logic [31:0] x;
    for (int j = 0; j < 16; j++) ew[j] = blk[j];
    for (int j = 16; j < 68; j++) begin
      x = ew[j-16] ^ ew[j-9] ^ rl(ew[j-3], 15);
      ew[j] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(ew[j-13], 7) ^ ew[j-6];
    end
  endtask
  task automatic send(input bit use64, input logic [31:0] blk [16], input bit lst, input int maxgap);
    int n;
    logic rdy;
    for (int i = 0; i < (use64 ? 8 : 16); i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      if (use64) begin
        b64.inpt_vld_i = 1'b1;
        b64.inpt_data_i = {blk[2*i], blk[2*i+1]};
        b64.inpt_lst_i = (i == 7) ? lst : 1'($urandom);
      end else begin
        b32.inpt_vld_i = 1'b1;
        b32.inpt_data_i = blk[i];
        b32.inpt_lst_i = (i == 15) ? lst : 1'($urandom);
      end
      n = 0;
      rdy = use64 ? b64.inpt_rdy_o : b32.inpt_rdy_o;
      while (!rdy && n < 300) begin
        @(negedge clk);
        n++;
        rdy = use64 ? b64.inpt_rdy_o : b32.inpt_rdy_o;
      end
      if (n >= 300) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout beat %0d: rdy stayed %b, required 1", i, rdy);
      end
      @(negedge clk);
      b32.inpt_vld_i = 1'b0;
      b64.inpt_vld_i = 1'b0;
      b32.inpt_data_i = 'x;
      b64.inpt_data_i = 'x;
    end
  endtask
  task automatic check_block(input bit use64, input bit lst, input string name);
    logic [31:0] wj, wjj;
    logic v, l, rd;
    for (int r = 0; r < 64; r++) begin
      if (r > 0) @(negedge clk);
      wj = use64 ? b64.expnd_otpt_wj_o : b32.expnd_otpt_wj_o;
      wjj = use64 ? b64.expnd_otpt_wjj_o : b32.expnd_otpt_wjj_o;
      v = use64 ? b64.expnd_otpt_vld_o : b32.expnd_otpt_vld_o;
      l = use64 ? b64.expnd_otpt_lst_o : b32.expnd_otpt_lst_o;
      rd = use64 ? b64.inpt_rdy_o : b32.inpt_rdy_o;
      got_wj[r] = wj;
      got_wjj[r] = wjj;
      checks++;
      if ({v, wj, wjj, l, rd} !== {1'b1, ew[r], ew[r] ^ ew[r+4], lst && r == 63, 1'b0}) begin
        errors++;
        $display("FAIL %s round %0d: vld=%b wj=%h wjj=%h lst=%b rdy=%b, required vld=1 wj=%h wjj=%h lst=%b rdy=0",
                 name, r, v, wj, wjj, l, rd, ew[r], ew[r] ^ ew[r+4], lst && r == 63);
      end
    end
    @(negedge clk);
    wj = use64 ? b64.expnd_otpt_wj_o : b32.expnd_otpt_wj_o;
    wjj = use64 ? b64.expnd_otpt_wjj_o : b32.expnd_otpt_wjj_o;
    v = use64 ? b64.expnd_otpt_vld_o : b32.expnd_otpt_vld_o;
    l = use64 ? b64.expnd_otpt_lst_o : b32.expnd_otpt_lst_o;
    rd = use64 ? b64.inpt_rdy_o : b32.inpt_rdy_o;
    checks++;
    if ({v, wj, wjj, l, rd} !== {1'b0, 64'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s after_round63: vld=%b wj=%h wjj=%h lst=%b rdy=%b, required vld=0 wj=0 wjj=0 lst=0 rdy=1",
               name, v, wj, wjj, l, rd);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({b32.inpt_rdy_o, b32.expnd_otpt_vld_o, b32.expnd_otpt_lst_o, b32.expnd_otpt_wj_o, b32.expnd_otpt_wjj_o,
         b64.inpt_rdy_o, b64.expnd_otpt_vld_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy32=%b vld32=%b lst32=%b wj32=%h wjj32=%h rdy64=%b vld64=%b, required all 0",
               b32.inpt_rdy_o, b32.expnd_otpt_vld_o, b32.expnd_otpt_lst_o, b32.expnd_otpt_wj_o,
               b32.expnd_otpt_wjj_o, b64.inpt_rdy_o, b64.expnd_otpt_vld_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({b32.inpt_rdy_o, b64.inpt_rdy_o} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_rdy: rdy32=%b rdy64=%b, required 1 1", b32.inpt_rdy_o, b64.inpt_rdy_o);
    end
    @(negedge clk);
  endtask
  task automatic test_abc(input bit use64);
    logic [31:0] exp_c [8];
    logic [31:0] got_c [8];
    for (int i = 0; i < 16; i++) blk_a[i] = 32'd0;
    blk_a[0] = 32'h61626380;
    blk_a[15] = 32'h00000018;
    model(blk_a);
    send(use64, blk_a, 1'b1, 0);
    check_block(use64, 1'b1, use64 ? "abc64" : "abc32");
    exp_c = '{32'h61626380, 32'h00000000, 32'h00000018, 32'h9092e200, 32'h00000000, 32'h000c0606, 32'h719c70ed, 32'h719c70f5};
    got_c = '{got_wj[0], got_wj[1], got_wj[15], got_wj[16], got_wj[17], got_wj[18], got_wj[19], got_wjj[15]};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_c[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL abc_vector dw%0d item %0d: got %h, required %h", use64 ? 64 : 32, i, got_c[i], exp_c[i]);
      end
    end
    checks++;
    if (got_wjj[0] !== 32'h61626380) begin
      errors++;
      $display("FAIL abc_wjj0 dw%0d: got %h, required 61626380", use64 ? 64 : 32, got_wjj[0]);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = $urandom;
      blk_b[i] = $urandom;
    end
    model(blk_a);
    send(1'b0, blk_a, 1'b0, 0);
    fork
      send(1'b0, blk_b, 1'b1, 0);
      check_block(1'b0, 1'b0, "b2b_blk1");
    join
    model(blk_b);
    check_block(1'b0, 1'b1, "b2b_blk2");
  endtask
  task automatic test_gaps(input bit use64);
    for (int i = 0; i < 16; i++) blk_a[i] = i;
    model(blk_a);
    send(use64, blk_a, 1'b1, 3);
    check_block(use64, 1'b1, use64 ? "gaps64" : "gaps32");
  endtask
  task automatic test_rst_run();
    for (int i = 0; i < 16; i++) blk_a[i] = $urandom;
    model(blk_a);
    send(1'b0, blk_a, 1'b1, 1);
    for (int r = 0; r <= 20; r++) begin
      if (r > 0) @(negedge clk);
      checks++;
      if ({b32.expnd_otpt_vld_o, b32.expnd_otpt_wj_o} !== {1'b1, ew[r]}) begin
        errors++;
        $display("FAIL abort_pre round %0d: vld=%b wj=%h, required vld=1 wj=%h", r, b32.expnd_otpt_vld_o,
                 b32.expnd_otpt_wj_o, ew[r]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({b32.expnd_otpt_vld_o, b32.expnd_otpt_wj_o, b32.expnd_otpt_wjj_o, b32.expnd_otpt_lst_o, b32.inpt_rdy_o} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: vld=%b wj=%h wjj=%h lst=%b rdy=%b, required all 0", b32.expnd_otpt_vld_o,
               b32.expnd_otpt_wj_o, b32.expnd_otpt_wjj_o, b32.expnd_otpt_lst_o, b32.inpt_rdy_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (b32.inpt_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_release_rdy: rdy=%b, required 1", b32.inpt_rdy_o);
    end
    for (int i = 0; i < 16; i++) blk_b[i] = $urandom;
    model(blk_b);
    send(1'b0, blk_b, 1'b0, 2);
    check_block(1'b0, 1'b0, "after_abort");
  endtask
  task automatic test_ones();
    for (int i = 0; i < 16; i++) blk_a[i] = 32'hffffffff;
    model(blk_a);
    send(1'b0, blk_a, 1'b1, 0);
    check_block(1'b0, 1'b1, "ones32");
    send(1'b1, blk_a, 1'b0, 1);
    check_block(1'b1, 1'b0, "ones64");
  endtask
  initial begin
    b32.inpt_vld_i = 1'b0;
    b32.inpt_lst_i = 1'b0;
    b32.inpt_data_i = '0;
    b64.inpt_vld_i = 1'b0;
    b64.inpt_lst_i = 1'b0;
    b64.inpt_data_i = '0;
    test_reset();
    test_abc(1'b0);
    test_abc(1'b1);
    test_back_to_back();
    test_gaps(1'b0);
    test_gaps(1'b1);
    test_rst_run();
    test_ones();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
